prog_sequencer: RTL and testbench

- Upstream feeder for the processor core. It replaces hand-entered switch data on DIN with a small loadable program memory.
- Issues one instruction per processor operation via Run, waits for Done, then advances its program counter.
- Drives the processor's DIN/Run inputs.
- Shares the processor's clock and is loaded from board switches while idle.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/prog_ram.sv | 30 +++
 rtl/prog_sequencer.sv | 159 +++++++++++++++
 tb/tb_prog_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the program sequencer: opcode encodings, opcode field
// position and FSM state encodings.
package seq_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam int OPC_HI = 5;
    localparam int OPC_LO = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_ADV   = 3'd3;
    localparam state_t ST_HALT  = 3'd4;
    localparam state_t ST_STALL = 3'd5;

    // mvi is the only two-word instruction.
    function automatic logic is_mvi(input logic [1:0] opc);
        return opc == OP_MVI;
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program memory: one synchronous write port, two combinational read ports
// (current word and the following word for mvi immediates).
module prog_ram #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer feeding DIN/Run of the processor core and waiting on Done.
// Optional single-step mode (Step input, STALL state) under SEQ_SINGLE_STEP_EN.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W  = 6,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Prog_We,
    input  logic [ADDR_W-1:0] Prog_Addr,
    input  logic [DATA_W-1:0] Prog_Wdata,
    input  logic [ADDR_W:0]   Prog_Len,
    input  logic              Done,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              Step,
`endif
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Halted,
    output logic              Fault
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

`ifdef SEQ_SINGLE_STEP_EN
    localparam state_t ST_ENTRY = ST_STALL;
`else
    localparam state_t ST_ENTRY = ST_ISSUE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mvi_q, mvi_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] din_q, din_s;
    logic [DATA_W-1:0] rd0_s, rd1_s;
    logic [ADDR_W:0]   pc_inc_s;
    logic              we_s;

    assign we_s     = Prog_We && ((state_q == ST_IDLE) || (state_q == ST_HALT));
    assign pc_inc_s = {1'b0, pc_q} + (mvi_q ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

    prog_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i    (Clock),
        .we_i     (we_s),
        .waddr_i  (Prog_Addr),
        .wdata_i  (Prog_Wdata),
        .raddr0_i (pc_q),
        .rdata0_o (rd0_s),
        .raddr1_i (pc_q + ADDR_W'(1)),
        .rdata1_o (rd1_s)
    );

    // Next-state logic for the sequencing FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        tmo_d   = tmo_q;
        mvi_d   = mvi_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    len_d   = Prog_Len;
                    pc_d    = '0;
                    fault_d = 1'b0;
                    state_d = (Prog_Len == '0) ? ST_HALT : ST_ENTRY;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                mvi_d   = is_mvi(rd0_s[OPC_HI:OPC_LO]);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (Done) begin
                    state_d = ST_ADV;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ADV: begin
                pc_d    = pc_inc_s[ADDR_W-1:0];
                state_d = (pc_inc_s >= len_q) ? ST_HALT : ST_ENTRY;
            end
            ST_STALL: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (Step) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_STALL;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // DIN mux: live memory word while an instruction is in flight, held otherwise.
    always_comb begin
        din_s = din_q;
        case (state_q)
            ST_ISSUE: din_s = rd0_s;
            ST_WAIT:  din_s = mvi_q ? rd1_s : rd0_s;
            default:  din_s = din_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            tmo_q   <= '0;
            mvi_q   <= 1'b0;
            fault_q <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
            mvi_q   <= mvi_d;
            fault_q <= fault_d;
            din_q   <= din_s;
        end
    end

    assign DIN    = din_s;
    assign Run    = (state_q == ST_ISSUE);
    assign PC     = pc_q;
    assign Halted = (state_q == ST_HALT);
    assign Fault  = fault_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed table, hand sequences for
// timeout / write-drop / reset, and a randomized run against an instruction-list model.
module tb_prog_sequencer;

    localparam int DATA_W  = 6;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst, start, we, done;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W:0]   plen;
    logic [DATA_W-1:0] din;
    logic              run, halted, fault;
    logic [ADDR_W-1:0] pc;
`ifdef SEQ_SINGLE_STEP_EN
    logic              step;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] model_mem [DEPTH];

    typedef struct {
        logic              done_nxt;
        logic              e_run;
        logic [DATA_W-1:0] e_din;
        logic [ADDR_W-1:0] e_pc;
        logic              e_halt;
    } vec_t;

    vec_t tbl [11];
    vec_t expq [$];

    always #5 clk = ~clk;

    prog_sequencer #(
        .DATA_W (DATA_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Start      (start),
        .Prog_We    (we),
        .Prog_Addr  (waddr),
        .Prog_Wdata (wdata),
        .Prog_Len   (plen),
        .Done       (done),
`ifdef SEQ_SINGLE_STEP_EN
        .Step       (step),
`endif
        .DIN        (din),
        .Run        (run),
        .PC         (pc),
        .Halted     (halted),
        .Fault      (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, "_run"}, 32'(run), 32'(v.e_run));
        check({tag, "_din"}, 32'(din), 32'(v.e_din));
        check({tag, "_pc"}, 32'(pc), 32'(v.e_pc));
        check({tag, "_halt"}, 32'(halted), 32'(v.e_halt));
    endtask

    task automatic write_word(input int a, input logic [DATA_W-1:0] d);
        we    = 1'b1;
        waddr = ADDR_W'(a);
        wdata = d;
        model_mem[a] = d;
        tick();
        we = 1'b0;
    endtask

    // Hold Done high until HALT or the budget runs out.
    task automatic wait_halted(input string name, input int budget);
        int i = 0;
        done = 1'b1;
        while (!halted && i < budget) begin
            tick();
            i++;
        end
        done = 1'b0;
        check(name, 32'(halted), 32'd1);
    endtask

    // Reference: walk the instruction list, emit per-cycle expectations.
    task automatic build_expect(input int len);
        int p = 0;
        int npc;
        int lat;
        logic [DATA_W-1:0] w, wd;
        logic mvi;
        expq.delete();
        forever begin
            w   = model_mem[p];
            mvi = (w[5:4] == 2'b01);
            wd  = mvi ? model_mem[(p + 1) % DEPTH] : w;
            lat = $urandom_range(1, 5);
            expq.push_back('{1'b0, 1'b1, w, ADDR_W'(p), 1'b0});
            for (int j = 1; j <= lat; j++)
                expq.push_back('{(j == lat), 1'b0, wd, ADDR_W'(p), 1'b0});
            expq.push_back('{1'b0, 1'b0, wd, ADDR_W'(p), 1'b0});
            npc = p + (mvi ? 2 : 1);
            if (npc >= len) begin
                expq.push_back('{1'b0, 1'b0, wd, ADDR_W'(npc % DEPTH), 1'b1});
                break;
            end
            p = npc;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; done = 1'b0;
        waddr = '0; wdata = '0; plen = '0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tbl[0]  = '{1'b0, 1'b1, 6'b010000, 4'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 6'b000101, 4'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 6'b000101, 4'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 6'b000101, 4'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 6'b000101, 4'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 6'b100000, 4'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 6'b100000, 4'd2, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 6'b100000, 4'd2, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 6'b100000, 4'd2, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 6'b100000, 4'd2, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 6'b100000, 4'd3, 1'b1};

        tick();
        tick();
        check_vec("reset", '{1'b0, 1'b0, 6'd0, 4'd0, 1'b0});
        check("reset_fault", 32'(fault), 32'd0);
        rst = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
        write_word(0, 6'b100000);
        write_word(1, 6'b110001);
        plen = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("step_stall_run", 32'(run), 32'd0);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_issue_run", 32'(run), 32'd1);
        check("step_issue_din", 32'(din), 32'b100000);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("step_after_run", 32'(run), 32'd0);
            check("step_after_pc", 32'(pc), 32'd1);
        end
`else
        // Prog_Len = 0: straight to HALT, never Run.
        plen = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_run_c1", 32'(run), 32'd0);
        tick();
        check("len0_run_c2", 32'(run), 32'd0);
        check("len0_halted", 32'(halted), 32'd1);

        // Directed mvi/add program; word 0 written in the same cycle as Start.
        write_word(1, 6'b000101);
        write_word(2, 6'b100000);
        we = 1'b1; waddr = 4'd0; wdata = 6'b010000; model_mem[0] = 6'b010000;
        plen = 5'd3; start = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
            we = 1'b0; start = 1'b0;
            check_vec($sformatf("tbl%0d", k), tbl[k]);
            done = tbl[k].done_nxt;
        end
        done = 1'b0;

        // Write attempted during WAIT must be dropped.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        we = 1'b1; waddr = 4'd0; wdata = 6'b111111;
        tick();
        we = 1'b0;
        wait_halted("wr_drop_halt1", 40);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wr_drop_run", 32'(run), 32'd1);
        check("wr_drop_din", 32'(din), 32'b010000);
        wait_halted("wr_drop_halt2", 40);

        // Done never returns: fault after TIMEOUT WAIT cycles.
        write_word(0, 6'b100000);
        plen = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) tick();
        check("tmo_fault_early", 32'(fault), 32'd0);
        check("tmo_halt_early", 32'(halted), 32'd0);
        tick();
        check("tmo_fault", 32'(fault), 32'd1);
        check("tmo_halted", 32'(halted), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tmo_fault_clr", 32'(fault), 32'd0);
        check("tmo_restart_run", 32'(run), 32'd1);
        wait_halted("tmo_halt2", 40);

        // Reset while waiting on the second instruction.
        write_word(1, 6'b110001);
        plen = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        tick();
        check("rst_pre_pc", 32'(pc), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("rst_mid", '{1'b0, 1'b0, 6'd0, 4'd0, 1'b0});
        check("rst_mid_fault", 32'(fault), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_vec("rst_restart", '{1'b0, 1'b1, 6'b100000, 4'd0, 1'b0});
        wait_halted("rst_halt", 60);

        // Randomized programs against the instruction-list model.
        for (int it = 0; it < 8; it++) begin
            int len;
            for (int a = 0; a < DEPTH; a++) write_word(a, DATA_W'($urandom));
            len = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
            build_expect(len);
            plen = (ADDR_W+1)'(len); start = 1'b1;
            for (int k = 0; k < expq.size(); k++) begin
                tick();
                start = 1'b0;
                check_vec($sformatf("rnd%0d_c%0d", it, k), expq[k]);
                done = expq[k].done_nxt;
            end
            done = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
